// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port:
// arbiter state encoding, owner codes and store-type byte-enable patterns
// that match the decode controller's Store encoding (funct3).
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Store type as encoded in the S-type funct3 field
  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_t;

  localparam logic [3:0] BE_SB = 4'b0001;
  localparam logic [3:0] BE_SH = 4'b0011;
  localparam logic [3:0] BE_SW = 4'b1111;

  // Byte enables for a store of the given type at the given word offset
  function automatic logic [3:0] store_be(input store_t st, input logic [1:0] off);
    logic [3:0] be;
    case (st)
      ST_SB:   be = BE_SB << off;
      ST_SH:   be = BE_SH << {off[1], 1'b0};
      ST_SW:   be = BE_SW;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/grant/response bus of the shared I/D memory port.
// master: the arbiter; slave: the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Transaction watchdog: clears while idle, counts while enabled and flags
// the cycle on which the count reaches TIMEOUT (the TIMEOUT-th enabled cycle).
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count and terminal-count detection
  always_comb begin
    cnt_d = cnt_q;
    tc    = en && (cnt_q == LAST);
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between fetch (IF) and
// the memory stage (DM). One transaction at a time: IDLE -> WAIT_GNT ->
// WAIT_RESP -> RESP. Data requests win over fetch; with FAIR_ARB_EN defined
// fetch wins a tie when the previous grant went to data.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_be,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  mem_port_arbiter_if.master    mem,
  output logic                  stall_f,
  output logic                  stall_m,
  output logic                  bus_err
);
  localparam int BE_W = DATA_W / 8;

  state_t              state_q,     state_d;
  logic                owner_q,     owner_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q,    mem_be_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                if_valid_q,  if_valid_d;
  logic                dm_valid_q,  dm_valid_d;
  logic                bus_err_q,   bus_err_d;
`ifdef FAIR_ARB_EN
  logic                last_owner_q, last_owner_d;
`endif

  logic grant_dm_s;
  logic tmo_clr_s;
  logic tmo_en_s;
  logic tmo_tc_s;

  assign tmo_clr_s = (state_q == IDLE);
  assign tmo_en_s  = (state_q == WAIT_GNT) || (state_q == WAIT_RESP);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr_s),
    .en    (tmo_en_s),
    .tc    (tmo_tc_s)
  );

  // Arbitration winner for an issue from IDLE
  always_comb begin
`ifdef FAIR_ARB_EN
    grant_dm_s = dm_req & ~(if_req & (last_owner_q == OWNER_DM));
`else
    grant_dm_s = dm_req;
`endif
  end

  // Transaction sequencer next-state and output-register computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    bus_err_d   = bus_err_q;
`ifdef FAIR_ARB_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      IDLE: begin
        if (dm_req || if_req) begin
          state_d   = WAIT_GNT;
          mem_req_d = 1'b1;
          if (grant_dm_s) begin
            owner_d     = OWNER_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_be_d    = dm_be;
          end else begin
            owner_d     = OWNER_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DATA_W{1'b0}};
            mem_be_d    = {BE_W{1'b1}};
          end
`ifdef FAIR_ARB_EN
          last_owner_d = grant_dm_s ? OWNER_DM : OWNER_IF;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_GNT, WAIT_RESP: begin
        if (tmo_tc_s) begin
          // Abort: flag the error and still answer so the pipeline moves on
          state_d   = RESP;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (owner_q == OWNER_DM) begin
            dm_rdata_d = {DATA_W{1'b0}};
            dm_valid_d = 1'b1;
          end else begin
            if_rdata_d = {DATA_W{1'b0}};
            if_valid_d = 1'b1;
          end
        end else if (state_q == WAIT_GNT) begin
          // A same-cycle rvalid is deliberately ignored here
          if (mem.gnt) begin
            state_d   = WAIT_RESP;
            mem_req_d = 1'b0;
          end else begin
            state_d = WAIT_GNT;
          end
        end else if (mem.rvalid) begin
          state_d = RESP;
          if (owner_q == OWNER_DM) begin
            dm_rdata_d = mem.rdata;
            dm_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem.rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          state_d = WAIT_RESP;
        end
      end

      RESP: begin
        // No arbitration here so a still-held request is not reissued
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_be_q    <= {BE_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef FAIR_ARB_EN
      last_owner_q <= OWNER_IF;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      bus_err_q   <= bus_err_d;
`ifdef FAIR_ARB_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;
  assign mem.be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign bus_err   = bus_err_q;
  assign stall_f   = if_req & ~if_valid_q;
  assign stall_m   = dm_req & ~dm_valid_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage and the memory stage of the pipelined RISC-V core.
- Sequences one transaction at a time over a req/gnt/rvalid memory handshake.
- Returns read data or write acknowledgements to the owning requester.
- Drives per-stage stall signals consumed by the hazard logic.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, max cycles spent in WAIT_GNT+WAIT_RESP before abort.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  instruction word (registered)
- if_valid  out  1  one-cycle response pulse to fetch
- dm_req  in  1  load/store request, held until dm_valid
- dm_we  in  1  1=store (from MemWrite)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data, already lane-aligned
- dm_be  in  DATA_W/8  byte enables derived from Store type
- dm_rdata  out  DATA_W  load word (registered; Load-type extension done downstream)
- dm_valid  out  1  one-cycle response pulse to memory stage
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_be  out  DATA_W/8  byte enables
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  DATA_W  read data
- stall_f  out  1  fetch must hold
- stall_m  out  1  memory stage must hold
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at posedge): state IDLE. mem_req, mem_we, if_valid, dm_valid, bus_err = 0. mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata = 0. Owner = IF. Timeout count = 0.
- States: IDLE, WAIT_GNT, WAIT_RESP, RESP.
- IDLE: if either req is high, arbitrate, latch owner plus addr/we/wdata/be into the mem_* registers, and go to WAIT_GNT (mem_req=1 next cycle).
  - Fetch access: mem_we=0, mem_be=all ones.
- Arbitration: dm_req wins over if_req (older instruction), unless FAIR_ARB_EN applies.
- WAIT_GNT: hold mem_req and all mem_* outputs stable. On mem_gnt=1, go to WAIT_RESP and drop mem_req.
- WAIT_RESP: on mem_rvalid=1, capture mem_rdata into the owner's rdata register (stores also update dm_rdata), then go to RESP.
- RESP: pulse the owner's valid for exactly one cycle, then IDLE. No arbitration in RESP; this prevents reissuing a still-held request.
- Minimum latency: request in IDLE -> valid asserted in 4th cycle (gnt and rvalid each one cycle after the previous state). Peak throughput: 1 access per 4 cycles.
- stall_f = if_req & ~if_valid. stall_m = dm_req & ~dm_valid. Both combinational.
- The non-owner rdata register holds its previous value.
- Timeout:
  - Counter clears on entering WAIT_GNT and increments each cycle in WAIT_GNT/WAIT_RESP.
  - When the count reaches TIMEOUT: bus_err=1 (sticky until reset), owner rdata=0, go to RESP (valid still pulses so the pipeline cannot deadlock), drop mem_req.
- mem_gnt or mem_rvalid outside the expected state is ignored (includes a late rvalid after reset or timeout).
- Simultaneous mem_gnt and mem_rvalid in WAIT_GNT: treat as gnt only; rvalid is not captured.
- Reset mid-transaction: outstanding access dropped, no valid pulse issued.
- Requester dropping req before valid: unsupported; the access still completes and valid still pulses.
- dm_addr[1:0] passes through unchanged; alignment is the requester's responsibility.

Optional Feature:
- Macro: FAIR_ARB_EN.
- Defined: 1-bit last_owner register (reset = IF). If both reqs are high in IDLE and last_owner==DM, fetch wins. This bounds fetch starvation to one data access.
- Undefined: fixed data-over-fetch priority; last_owner not instantiated.

Decomposition:
- Shared package riscv_mem_pkg:
  - state enum (IDLE, WAIT_GNT, WAIT_RESP, RESP)
  - owner constants OWNER_IF=0, OWNER_DM=1
  - BE_WORD all-ones constant
  - store-type-to-byte-enable constants shared with the decode controller's Store encoding
- One sub-module, mem_timeout_ctr: clear/enable counter with terminal-count output at TIMEOUT.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, gnt one cycle after req, rvalid+rdata=0x00500093 one cycle later -> if_rdata=0x00500093, if_valid pulses once in cycle 4, stall_f low after.
- Simultaneous: if_req and dm_req (load 0x2000) both high -> data access first, fetch issued after the RESP cycle. With FAIR_ARB_EN and a second load pending, fetch wins the next arbitration.
- Store: dm_we=1, dm_addr=0x2004, dm_wdata=0x000000AB, dm_be=0001 -> mem_be=0001, mem_we=1 held through WAIT_GNT; dm_valid pulses after the ack.
- Gnt delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles; stall_m high throughout.
- Memory never responds, TIMEOUT=8 -> bus_err=1 after 8 cycles, dm_valid pulses with dm_rdata=0; a later mem_rvalid is ignored.
- reset low during WAIT_RESP -> next cycle IDLE, mem_req=0, no valid pulse; a subsequent rvalid is ignored.
